// File: rtl/flag_scoreboard.sv
// flag_scoreboard: issue-side hazard controller for the flags register.
// Tracks in-flight flag writers, stalls flag/carry readers on RAW hazards,
// aligns each writer's carry select with its write-back cycle, kills young
// writers on flush and counts stall cycles (saturating).
// Optional feature: define FLAG_FWD_EN to let a reader issue while the only
// pending writer is in its write-back stage, selecting forwarded ALU flags.
module flag_scoreboard #(
  parameter int unsigned FLAG_LATENCY = 3,
  parameter int unsigned KILL_DEPTH   = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid,
  input  logic                 dec_writes_flags,
  input  logic                 dec_reads_flags,
  input  logic [1:0]           dec_carry_sel,
  input  logic                 flush,
  output logic                 dec_ready,
  output logic                 flags_we,
  output logic [1:0]           carry_sel_wb,
  output logic                 fwd_sel,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam int unsigned L    = FLAG_LATENCY;
  localparam int          KILL = int'(KILL_DEPTH);

  logic [L-1:0]      pend;
  logic [L-1:0]      pendNext;
  logic [L-1:0][1:0] cs;
  logic [L-1:0][1:0] csNext;
  logic              haz;
  logic              issue;
  logic              push;
  logic              stallInc;

  // Hazard: with forwarding the write-back stage is not a hazard
`ifdef FLAG_FWD_EN
  assign haz = dec_reads_flags & (pend[L-2:0] != '0);
`else
  assign haz = dec_reads_flags & (pend != '0);
`endif

  assign dec_ready    = ~haz & ~flush;
  assign issue        = dec_valid & dec_ready;
  assign push         = issue & dec_writes_flags;
  assign stallInc     = dec_valid & ~dec_ready & ~flush;
  assign flags_we     = pend[L-1];
  assign carry_sel_wb = pend[L-1] ? cs[L-1] : 2'b00;

  // Next scoreboard: kill the youngest stages on flush, then shift and push
  always_comb begin
    pendNext = '0;
    csNext   = '0;
    for (int i = 1; i < int'(L); i++) begin
      if (pend[i-1] && !(flush && ((i - 1) < KILL))) begin
        pendNext[i] = 1'b1;
        csNext[i]   = cs[i-1];
      end
    end
    if (push) begin
      pendNext[0] = 1'b1;
      csNext[0]   = dec_carry_sel;
    end
  end

  // Scoreboard and saturating stall counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend        <= '0;
      cs          <= '0;
      stall_count <= '0;
    end else begin
      pend <= pendNext;
      cs   <= csNext;
      if (stallInc && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_WIDTH'(1);
      end
    end
  end

`ifdef FLAG_FWD_EN
  // Reader issued against a writer in its write-back stage takes forwarded flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_sel <= 1'b0;
    end else begin
      fwd_sel <= issue & dec_reads_flags & pend[L-1];
    end
  end
`else
  assign fwd_sel = 1'b0;
`endif

endmodule

// File: tb/tb_flag_scoreboard.sv
// Directed self-checking bench for flag_scoreboard (L=3, KILL_DEPTH=2, CNT_WIDTH=16).
module tb_flag_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        dec_valid;
  logic        dec_writes_flags;
  logic        dec_reads_flags;
  logic [1:0]  dec_carry_sel;
  logic        flush;
  logic        dec_ready;
  logic        flags_we;
  logic [1:0]  carry_sel_wb;
  logic        fwd_sel;
  logic [15:0] stall_count;

  int passCount  = 0;
  int checkCount = 0;
  int expStall   = 0;

  flag_scoreboard #(
    .FLAG_LATENCY(3),
    .KILL_DEPTH(2),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dec_valid(dec_valid),
    .dec_writes_flags(dec_writes_flags),
    .dec_reads_flags(dec_reads_flags),
    .dec_carry_sel(dec_carry_sel),
    .flush(flush),
    .dec_ready(dec_ready),
    .flags_we(flags_we),
    .carry_sel_wb(carry_sel_wb),
    .fwd_sel(fwd_sel),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply decode inputs for the current cycle and let combinational outputs settle
  task automatic drive(input logic v, input logic w, input logic r, input logic [1:0] c, input logic f);
    dec_valid        = v;
    dec_writes_flags = w;
    dec_reads_flags  = r;
    dec_carry_sel    = c;
    flush            = f;
    #1;
  endtask

  // Advance to the next cycle: past the rising edge
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    idle();

    // Reset with random inputs for two edges
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
      nextCycle();
    end
    rst_n = 1'b1;
    idle();
    check("rst_flags_we", 32'(flags_we), 0);
    check("rst_carry_sel_wb", 32'(carry_sel_wb), 0);
    check("rst_fwd_sel", 32'(fwd_sel), 0);
    check("rst_stall_count", 32'(stall_count), 0);
    check("rst_dec_ready", 32'(dec_ready), 1);

    // Writer latency: issue at t0 with carry_sel=10
    nextCycle();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    check("lat_t0_ready", 32'(dec_ready), 1);
    nextCycle(); idle();
    check("lat_t1_we", 32'(flags_we), 0);
    nextCycle(); idle();
    check("lat_t2_we", 32'(flags_we), 0);
    nextCycle(); idle();
    check("lat_t3_we", 32'(flags_we), 1);
    check("lat_t3_cs", 32'(carry_sel_wb), 32'h2);
    nextCycle(); idle();
    check("lat_t4_we", 32'(flags_we), 0);
    check("lat_t4_cs", 32'(carry_sel_wb), 0);

    // Back-to-back writers plus an independent instruction never stalled
    nextCycle();
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    nextCycle();
    drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    check("b2b_t1_ready", 32'(dec_ready), 1);
    nextCycle();
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    check("indep_ready", 32'(dec_ready), 1);
    nextCycle(); idle();
    check("b2b_t3_we", 32'(flags_we), 1);
    check("b2b_t3_cs", 32'(carry_sel_wb), 32'h1);
    nextCycle(); idle();
    check("b2b_t4_we", 32'(flags_we), 1);
    check("b2b_t4_cs", 32'(carry_sel_wb), 32'h3);
    nextCycle(); idle();
    check("b2b_t5_we", 32'(flags_we), 0);

    // RAW stall: writer at t0, reader held from t1
    nextCycle();
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    nextCycle();
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    check("raw_t1_ready", 32'(dec_ready), 0);
    nextCycle();
    check("raw_t2_ready", 32'(dec_ready), 0);
    nextCycle();
`ifdef FLAG_FWD_EN
    check("raw_t3_ready", 32'(dec_ready), 1);
    check("raw_t3_we", 32'(flags_we), 1);
    nextCycle(); idle();
    expStall += 2;
    check("raw_t4_fwd", 32'(fwd_sel), 1);
    check("raw_stall", 32'(stall_count), 32'(expStall));
    nextCycle(); idle();
    check("raw_t5_fwd", 32'(fwd_sel), 0);
`else
    check("raw_t3_ready", 32'(dec_ready), 0);
    nextCycle();
    check("raw_t4_ready", 32'(dec_ready), 1);
    nextCycle(); idle();
    expStall += 3;
    check("raw_stall", 32'(stall_count), 32'(expStall));
    check("raw_fwd", 32'(fwd_sel), 0);
`endif

    // Flush at t1 kills a writer in pend[0]
    nextCycle();
    drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    nextCycle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    check("fl1_ready", 32'(dec_ready), 0);
    nextCycle(); idle();
    nextCycle(); idle();
    check("fl1_t3_we", 32'(flags_we), 0);
    nextCycle(); idle();
    check("fl1_t4_we", 32'(flags_we), 0);

    // Flush at t2 kills a writer in pend[1]
    nextCycle();
    drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    nextCycle(); idle();
    nextCycle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    nextCycle(); idle();
    check("fl2_t3_we", 32'(flags_we), 0);
    check("fl2_t3_cs", 32'(carry_sel_wb), 0);

    // Flush at t3 leaves a writer in its write-back stage alone
    nextCycle();
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    nextCycle(); idle();
    nextCycle(); idle();
    nextCycle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    check("fl3_t3_we", 32'(flags_we), 1);
    check("fl3_t3_cs", 32'(carry_sel_wb), 32'h1);
    nextCycle(); idle();
    check("fl3_t4_we", 32'(flags_we), 0);

    // Flush vs issue: a writer presented during flush is dropped, not counted
    nextCycle();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b1);
    check("fvi_ready", 32'(dec_ready), 0);
    nextCycle(); idle();
    check("fvi_stall", 32'(stall_count), 32'(expStall));
    nextCycle(); idle();
    nextCycle(); idle();
    check("fvi_t3_we", 32'(flags_we), 0);
    nextCycle(); idle();
    check("fvi_t4_we", 32'(flags_we), 0);

    // Saturation: a read-and-write instruction held forever keeps the scoreboard busy
    drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
    cyc = 0;
    while ((stall_count !== 16'hFFFF) && (cyc < 99000)) begin
      nextCycle();
      cyc++;
    end
    check("sat_reached", 32'(stall_count), 32'hFFFF);
    for (int i = 0; i < 8; i++) nextCycle();
    check("sat_hold", 32'(stall_count), 32'hFFFF);
    idle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
